// File: rtl/chess_move_timer.sv
// Two-player chess countdown clock: runs the side-to-move, flags on zero, freezes on checkmate.
// Define CHESS_TIMER_INCREMENT_EN to add INCREMENT_SECONDS to the mover's clock on each move.
module chess_move_timer #(
  parameter int unsigned CLOCK_FREQUENCY   = 50000000,
  parameter int unsigned START_SECONDS     = 300,
  parameter int unsigned INCREMENT_SECONDS = 5,
  parameter int unsigned TIME_WIDTH        = 12
) (
  input  logic                  clock,
  input  logic                  resetApp,
  input  logic                  Player,
  input  logic [1:0]            Checkmate,
  input  logic                  Pause,
  output logic [TIME_WIDTH-1:0] WhiteSeconds,
  output logic [TIME_WIDTH-1:0] BlackSeconds,
  output logic [15:0]           ActiveDigits,
  output logic [1:0]            Timeout,
  output logic                  GameOver
);

  // state  | meaning
  // RUN    | active side's clock counts down, moves/checkmate/flag-fall honoured
  // FROZEN | game over (flag or checkmate); everything holds until reset
  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_e;

  localparam int unsigned PRESC_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(CLOCK_FREQUENCY - 1);
  localparam logic [TIME_WIDTH-1:0] START_VAL  = TIME_WIDTH'(START_SECONDS);

  function automatic logic [15:0] to_bcd(input logic [TIME_WIDTH-1:0] secs);
    int unsigned total;
    int unsigned mins;
    int unsigned rem;
    total = 32'(secs);
    mins  = total / 60;
    if (mins > 99) mins = 99;
    rem   = total % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(rem / 10), 4'(rem % 10)};
  endfunction

  localparam logic [15:0] DIGITS_RST = to_bcd(START_VAL);

`ifdef CHESS_TIMER_INCREMENT_EN
  localparam logic [TIME_WIDTH:0] INC_EXT = (TIME_WIDTH+1)'(INCREMENT_SECONDS);

  function automatic logic [TIME_WIDTH-1:0] sat_add(input logic [TIME_WIDTH-1:0] a);
    logic [TIME_WIDTH:0] sum;
    sum = {1'b0, a} + INC_EXT;
    return sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
  endfunction
`else
  // Increment is compiled out; keep the parameter referenced so it stays visible.
  localparam int unsigned unused_increment = INCREMENT_SECONDS;
`endif

  state_e state_q, state_d;

  logic player_s1_q, player_s2_q, player_prev_q;
  logic mate_s1_q, mate_s2_q;
  logic pause_s1_q, pause_s2_q;
  logic unused_winner;

  logic [TIME_WIDTH-1:0] white_q, white_d, black_q, black_d;
  logic                  active_q, active_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [1:0]            timeout_q, timeout_d;
  logic [15:0]           digits_q, digits_d;

  logic                  running, move, tick, flag_fall;
  logic [TIME_WIDTH-1:0] active_cnt;

  // The winner bit of Checkmate is implied by the board stage; only the end flag matters here.
  assign unused_winner = Checkmate[1];

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      player_s1_q   <= 1'b1;
      player_s2_q   <= 1'b1;
      player_prev_q <= 1'b1;
      mate_s1_q     <= 1'b0;
      mate_s2_q     <= 1'b0;
      pause_s1_q    <= 1'b0;
      pause_s2_q    <= 1'b0;
    end else begin
      player_s1_q   <= Player;
      player_s2_q   <= player_s1_q;
      player_prev_q <= player_s2_q;
      mate_s1_q     <= Checkmate[0];
      mate_s2_q     <= mate_s1_q;
      pause_s1_q    <= Pause;
      pause_s2_q    <= pause_s1_q;
    end
  end

  always_comb begin
    running    = (state_q == RUN);
    active_cnt = active_q ? white_q : black_q;
    move       = (player_s2_q != player_prev_q);
    tick       = running && !pause_s2_q && (presc_q == PRESC_LAST);
    flag_fall  = tick && !mate_s2_q && !move && (active_cnt == TIME_WIDTH'(1));
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mate_s2_q || flag_fall) state_d = FROZEN;
      FROZEN:  state_d = FROZEN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    GameOver = (state_q == FROZEN);
  end

  // Priority inside RUN: checkmate, then move, then pause, then tick.
  always_comb begin
    white_d   = white_q;
    black_d   = black_q;
    active_d  = active_q;
    presc_d   = presc_q;
    timeout_d = timeout_q;
    digits_d  = to_bcd(active_cnt);
    if (running && !mate_s2_q) begin
      if (move) begin
        active_d = player_s2_q;
        presc_d  = '0;
`ifdef CHESS_TIMER_INCREMENT_EN
        if (active_q) white_d = sat_add(white_q);
        else          black_d = sat_add(black_q);
`endif
      end else if (!pause_s2_q) begin
        if (tick) begin
          presc_d = '0;
          if (active_cnt != '0) begin
            if (active_q) white_d = white_q - 1'b1;
            else          black_d = black_q - 1'b1;
          end
          if (flag_fall) timeout_d = {~active_q, 1'b1};
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      white_q   <= START_VAL;
      black_q   <= START_VAL;
      active_q  <= 1'b1;
      presc_q   <= '0;
      timeout_q <= 2'b00;
      digits_q  <= DIGITS_RST;
    end else begin
      white_q   <= white_d;
      black_q   <= black_d;
      active_q  <= active_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      digits_q  <= digits_d;
    end
  end

  assign WhiteSeconds = white_q;
  assign BlackSeconds = black_q;
  assign ActiveDigits = digits_q;
  assign Timeout      = timeout_q;

endmodule

// File: tb/tb_chess_move_timer.sv
// Scoreboard bench for chess_move_timer: expected output changes are queued with their
// cycle number and compared whenever the main instance's outputs change.
module tb_chess_move_timer;

  logic        clock = 1'b0;
  logic        resetApp = 1'b1;
  logic        Player = 1'b1;
  logic [1:0]  Checkmate = 2'b00;
  logic        Pause = 1'b0;

  logic [11:0] WhiteSeconds, BlackSeconds;
  logic [15:0] ActiveDigits;
  logic [1:0]  Timeout;
  logic        GameOver;

  logic [3:0]  b_white, b_black;
  logic [15:0] b_digits;
  logic [1:0]  b_timeout;
  logic        b_gameover;

  logic [11:0] c_white, c_black;
  logic [15:0] c_digits;
  logic [1:0]  c_timeout;
  logic        c_gameover;

  always #5 clock = ~clock;

  chess_move_timer #(.CLOCK_FREQUENCY(4), .START_SECONDS(3), .INCREMENT_SECONDS(2), .TIME_WIDTH(12)) dut (
    .clock(clock), .resetApp(resetApp), .Player(Player), .Checkmate(Checkmate), .Pause(Pause),
    .WhiteSeconds(WhiteSeconds), .BlackSeconds(BlackSeconds), .ActiveDigits(ActiveDigits),
    .Timeout(Timeout), .GameOver(GameOver));

  chess_move_timer #(.CLOCK_FREQUENCY(2), .START_SECONDS(15), .INCREMENT_SECONDS(5), .TIME_WIDTH(4)) dut_b (
    .clock(clock), .resetApp(resetApp), .Player(Player), .Checkmate(Checkmate), .Pause(Pause),
    .WhiteSeconds(b_white), .BlackSeconds(b_black), .ActiveDigits(b_digits),
    .Timeout(b_timeout), .GameOver(b_gameover));

  chess_move_timer #(.CLOCK_FREQUENCY(4), .START_SECONDS(125), .INCREMENT_SECONDS(5), .TIME_WIDTH(12)) dut_c (
    .clock(clock), .resetApp(resetApp), .Player(Player), .Checkmate(Checkmate), .Pause(Pause),
    .WhiteSeconds(c_white), .BlackSeconds(c_black), .ActiveDigits(c_digits),
    .Timeout(c_timeout), .GameOver(c_gameover));

  typedef struct packed {
    logic [11:0] w;
    logic [11:0] b;
    logic [1:0]  to;
    logic        go;
    logic [15:0] dig;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  int    sat_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    tick_cnt = 0;
  int    base_cnt = 0;
  bit    mon_en = 1'b0;
  snap_t prev_s;
  snap_t mon_cur;
  exp_t  mon_e;

  function automatic snap_t cur_snap();
    return {WhiteSeconds, BlackSeconds, Timeout, GameOver, ActiveDigits};
  endfunction

  function automatic void push(int c, int w, int b, logic [1:0] to, logic go, logic [15:0] dig);
    exp_t e;
    e.cyc   = c;
    e.s.w   = 12'(w);
    e.s.b   = 12'(b);
    e.s.to  = to;
    e.s.go  = go;
    e.s.dig = dig;
    exp_q.push_back(e);
  endfunction

  // Output monitor: every change of the main instance pops one expected event.
  always @(posedge clock) begin
    #1;
    tick_cnt = tick_cnt + 1;
    mon_cur  = cur_snap();
    if (mon_en && (mon_cur !== prev_s)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", tick_cnt - base_cnt, mon_cur);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != (tick_cnt - base_cnt) || mon_e.s !== mon_cur) begin
          mismatched++;
          $display("FAIL event got cyc=%0d w/b/to/go/dig=%h required cyc=%0d %h",
                   tick_cnt - base_cnt, mon_cur, mon_e.cyc, mon_e.s);
        end
      end
    end
    prev_s = mon_cur;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clock);
    resetApp  = 1'b1;
    Player    = 1'b1;
    Checkmate = 2'b00;
    Pause     = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clock);
    resetApp = 1'b0;
    base_cnt = tick_cnt;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    resetApp = 1'b1;
    repeat (3) @(negedge clock);
    compared += 14;
    if (WhiteSeconds !== 12'd3)    begin mismatched++; $display("FAIL rst_white got=%0d required=3", WhiteSeconds); end
    if (BlackSeconds !== 12'd3)    begin mismatched++; $display("FAIL rst_black got=%0d required=3", BlackSeconds); end
    if (Timeout !== 2'b00)         begin mismatched++; $display("FAIL rst_timeout got=%b required=00", Timeout); end
    if (GameOver !== 1'b0)         begin mismatched++; $display("FAIL rst_gameover got=%b required=0", GameOver); end
    if (ActiveDigits !== 16'h0003) begin mismatched++; $display("FAIL rst_digits got=%h required=0003", ActiveDigits); end
    if (b_white !== 4'd15)         begin mismatched++; $display("FAIL rst_b_white got=%0d required=15", b_white); end
    if (b_black !== 4'd15)         begin mismatched++; $display("FAIL rst_b_black got=%0d required=15", b_black); end
    if (b_digits !== 16'h0015)     begin mismatched++; $display("FAIL rst_b_digits got=%h required=0015", b_digits); end
    if (b_timeout !== 2'b00)       begin mismatched++; $display("FAIL rst_b_timeout got=%b required=00", b_timeout); end
    if (b_gameover !== 1'b0)       begin mismatched++; $display("FAIL rst_b_gameover got=%b required=0", b_gameover); end
    if (c_white !== 12'd125)       begin mismatched++; $display("FAIL rst_c_white got=%0d required=125", c_white); end
    if (c_black !== 12'd125)       begin mismatched++; $display("FAIL rst_c_black got=%0d required=125", c_black); end
    if (c_digits !== 16'h0205)     begin mismatched++; $display("FAIL rst_c_digits got=%h required=0205", c_digits); end
    if (c_timeout !== 2'b00 || c_gameover !== 1'b0) begin
      mismatched++; $display("FAIL rst_c_end got=%b/%b required=00/0", c_timeout, c_gameover);
    end
  endtask

  task automatic test_flag();
    do_reset();
    push(4,  2, 3, 2'b00, 1'b0, 16'h0003);
    push(5,  2, 3, 2'b00, 1'b0, 16'h0002);
    push(8,  1, 3, 2'b00, 1'b0, 16'h0002);
    push(9,  1, 3, 2'b00, 1'b0, 16'h0001);
    push(12, 0, 3, 2'b01, 1'b1, 16'h0001);
    push(13, 0, 3, 2'b01, 1'b1, 16'h0000);
    mon_en = 1'b1;
    repeat (40) @(negedge clock);
    mon_en = 1'b0;
    compared += 3;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL flag_pending got=%0d required=0", exp_q.size()); end
    if (WhiteSeconds !== 12'd0 || BlackSeconds !== 12'd3) begin
      mismatched++; $display("FAIL flag_frozen got=%0d/%0d required=0/3", WhiteSeconds, BlackSeconds);
    end
    if (Timeout !== 2'b01 || GameOver !== 1'b1) begin
      mismatched++; $display("FAIL flag_end got=%b/%b required=01/1", Timeout, GameOver);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clock);
    #3 resetApp = 1'b1;
    #1;
    compared += 2;
    if (WhiteSeconds !== 12'd3 || BlackSeconds !== 12'd3 || ActiveDigits !== 16'h0003) begin
      mismatched++;
      $display("FAIL midrst_counters got=%0d/%0d/%h required=3/3/0003", WhiteSeconds, BlackSeconds, ActiveDigits);
    end
    if (Timeout !== 2'b00 || GameOver !== 1'b0) begin
      mismatched++; $display("FAIL midrst_end got=%b/%b required=00/0", Timeout, GameOver);
    end
  endtask

  task automatic test_move();
    int wexp;
    do_reset();
`ifdef CHESS_TIMER_INCREMENT_EN
    wexp = 4;
`else
    wexp = 2;
`endif
    push(4, 2, 3, 2'b00, 1'b0, 16'h0002 + 16'h0001);
    push(5, 2, 3, 2'b00, 1'b0, 16'h0002);
`ifdef CHESS_TIMER_INCREMENT_EN
    push(8, wexp, 3, 2'b00, 1'b0, 16'h0002);
`endif
    push(9,  wexp, 3, 2'b00, 1'b0, 16'h0003);
    push(12, wexp, 2, 2'b00, 1'b0, 16'h0003);
    push(13, wexp, 2, 2'b00, 1'b0, 16'h0002);
    push(16, wexp, 1, 2'b00, 1'b0, 16'h0002);
    push(17, wexp, 1, 2'b00, 1'b0, 16'h0001);
    push(20, wexp, 0, 2'b11, 1'b1, 16'h0001);
    push(21, wexp, 0, 2'b11, 1'b1, 16'h0000);
    mon_en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (c == 5) Player = 1'b0;
    end
    mon_en = 1'b0;
    compared += 2;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL move_pending got=%0d required=0", exp_q.size()); end
    if (WhiteSeconds !== 12'(wexp) || Timeout !== 2'b11) begin
      mismatched++; $display("FAIL move_end got=%0d/%b required=%0d/11", WhiteSeconds, Timeout, wexp);
    end
  endtask

  task automatic test_checkmate();
    int wexp;
    do_reset();
`ifdef CHESS_TIMER_INCREMENT_EN
    wexp = 5;
    push(4, wexp, 3, 2'b00, 1'b0, 16'h0003);
`else
    wexp = 3;
`endif
    push(8,  wexp, 2, 2'b00, 1'b0, 16'h0003);
    push(9,  wexp, 2, 2'b00, 1'b0, 16'h0002);
    push(12, wexp, 1, 2'b00, 1'b0, 16'h0002);
    push(13, wexp, 1, 2'b00, 1'b0, 16'h0001);
    push(16, wexp, 1, 2'b00, 1'b1, 16'h0001);
    mon_en = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clock);
      if (c == 1)  Player = 1'b0;
      if (c == 13) Checkmate = 2'b11;
      if (c == 30) Checkmate = 2'b00;
      if (c == 50) Player = 1'b1;
    end
    mon_en = 1'b0;
    compared += 2;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL mate_pending got=%0d required=0", exp_q.size()); end
    if (WhiteSeconds !== 12'(wexp) || BlackSeconds !== 12'd1 || Timeout !== 2'b00 || GameOver !== 1'b1) begin
      mismatched++;
      $display("FAIL mate_end got=%0d/%0d/%b/%b required=%0d/1/00/1", WhiteSeconds, BlackSeconds, Timeout, GameOver, wexp);
    end
  endtask

  task automatic test_pause();
    do_reset();
    push(4,  2, 3, 2'b00, 1'b0, 16'h0003);
    push(5,  2, 3, 2'b00, 1'b0, 16'h0002);
    push(28, 1, 3, 2'b00, 1'b0, 16'h0002);
    push(29, 1, 3, 2'b00, 1'b0, 16'h0001);
    push(32, 0, 3, 2'b01, 1'b1, 16'h0001);
    push(33, 0, 3, 2'b01, 1'b1, 16'h0000);
    mon_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 5)  Pause = 1'b1;
      if (c == 25) Pause = 1'b0;
      if (c == 20) begin
        compared++;
        if (WhiteSeconds !== 12'd2) begin
          mismatched++; $display("FAIL pause_hold got=%0d required=2", WhiteSeconds);
        end
      end
    end
    mon_en = 1'b0;
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL pause_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    Player = 1'b0;
`ifdef CHESS_TIMER_INCREMENT_EN
    sat_q.push_back(15);
    sat_q.push_back(130);
`else
    sat_q.push_back(14);
    sat_q.push_back(125);
`endif
    sat_q.push_back(12);
    sat_q.push_back(124);
    repeat (10) @(negedge clock);
    compared += 6;
    e = sat_q.pop_front();
    if (b_white !== 4'(e))   begin mismatched++; $display("FAIL sat_b_white got=%0d required=%0d", b_white, e); end
    e = sat_q.pop_front();
    if (c_white !== 12'(e))  begin mismatched++; $display("FAIL sat_c_white got=%0d required=%0d", c_white, e); end
    e = sat_q.pop_front();
    if (b_black !== 4'(e))   begin mismatched++; $display("FAIL sat_b_black got=%0d required=%0d", b_black, e); end
    e = sat_q.pop_front();
    if (c_black !== 12'(e))  begin mismatched++; $display("FAIL sat_c_black got=%0d required=%0d", c_black, e); end
    if (b_digits !== 16'h0012) begin mismatched++; $display("FAIL sat_b_digits got=%h required=0012", b_digits); end
    if (c_digits !== 16'h0204) begin mismatched++; $display("FAIL sat_c_digits got=%h required=0204", c_digits); end
  endtask

  initial begin
    test_reset();
    test_flag();
    test_reset_mid();
    test_move();
    test_checkmate();
    test_pause();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
